// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op in flight; special cases finish the cycle after accept, others take 32 CALC cycles.
`ifndef ROB_LEN
`define ROB_LEN 32
`endif
`ifndef DIV
`define DIV 3'b100
`endif
`ifndef DIVU
`define DIVU 3'b101
`endif
`ifndef REM
`define REM 3'b110
`endif
`ifndef REMU
`define REMU 3'b111
`endif

module div_unit (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  funct3,
   input  logic [31:0]                 rs1_data,
   input  logic [31:0]                 rs2_data,
   input  logic                        div_i_valid,
   input  logic [$clog2(`ROB_LEN)-1:0] div_i_rob_idx,
   input  logic [6:0]                  div_i_rd,
   input  logic                        div_flush,
   output logic                        div_o_valid,
   output logic [$clog2(`ROB_LEN)-1:0] div_o_rob_idx,
   output logic [6:0]                  div_o_rd,
   output logic [31:0]                 div_o_data,
   output logic                        div_idle
);
   localparam int ROB_W = $clog2(`ROB_LEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [4:0]         count;
   logic [1:0]         op;
   logic [ROB_W-1:0]   rob_idx;
   logic [6:0]         rd;
   logic [31:0]        divisor, quo, rem;
   logic               q_neg, r_neg;

   logic signed [31:0] a_s, b_s;
   logic               is_signed, accept, special, div_zero, overflow;
   logic [32:0]        shifted, trial;
   logic [31:0]        quo_step, rem_step, special_res, final_res;

   function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic sgn);
      return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   assign a_s       = rs1_data;
   assign b_s       = rs2_data;
   assign is_signed = ~funct3[0];
   assign accept    = (state == IDLE) && div_i_valid && !div_flush;
   assign div_zero  = (rs2_data == 32'd0);
   assign overflow  = is_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
   assign special   = !funct3[2] || div_zero || overflow;

   always_comb begin
      special_res = 32'd0;
      if (funct3[2]) begin
         if (div_zero)
            special_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
         else if (overflow)
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // One restoring step: shift the next dividend bit in, keep the subtraction if it did not borrow
   assign shifted   = {rem, quo[31]};
   assign trial     = shifted - {1'b0, divisor};
   assign rem_step  = trial[32] ? shifted[31:0] : trial[31:0];
   assign quo_step  = {quo[30:0], ~trial[32]};
   assign final_res = op[1] ? fix_sign(rem_step, r_neg & ~op[0])
                            : fix_sign(quo_step, q_neg & ~op[0]);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? DONE : CALC;
         CALC:    if (div_flush) state_nxt = IDLE;
                  else if (count == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign div_idle    = (state == IDLE);
   assign div_o_valid = (state == DONE) && !div_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         count         <= 5'd0;
         div_o_data    <= 32'd0;
         div_o_rob_idx <= '0;
         div_o_rd      <= 7'd0;
      end else if (accept) begin
         count <= 5'd0;
         if (special) begin
            div_o_data    <= special_res;
            div_o_rob_idx <= div_i_rob_idx;
            div_o_rd      <= div_i_rd;
         end
      end else if (state == CALC) begin
         count <= count + 5'd1;
         if (!div_flush && count == 5'd31) begin
            div_o_data    <= final_res;
            div_o_rob_idx <= rob_idx;
            div_o_rd      <= rd;
         end
      end
   end

   // Operand and tag holding registers carry no reset; they are always loaded at accept
   always_ff @(posedge clk) begin
      if (accept) begin
         op      <= funct3[1:0];
         rob_idx <= div_i_rob_idx;
         rd      <= div_i_rd;
         quo     <= magnitude(a_s, is_signed);
         divisor <= magnitude(b_s, is_signed);
         rem     <= 32'd0;
         q_neg   <= rs1_data[31] ^ rs2_data[31];
         r_neg   <= rs1_data[31];
      end else if (state == CALC) begin
         quo <= quo_step;
         rem <= rem_step;
      end
   end

endmodule
